// File: rtl/stream_pattern_checker_if.sv
// Bus-address/strobe and FWFT stream signals of stream_pattern_checker.
// The shared 8-bit bus data line stays a plain inout port on the checker itself.
interface stream_pattern_checker_if #(
   parameter int unsigned ABUSWIDTH = 16
);
   logic [ABUSWIDTH-1:0] BUS_ADD;
   logic                 BUS_RD;
   logic                 BUS_WR;
   logic [31:0]          FIFO_DATA;
   logic                 FIFO_EMPTY;
   logic                 FIFO_READ;

   modport master (
      output BUS_ADD,
      output BUS_RD,
      output BUS_WR,
      output FIFO_DATA,
      output FIFO_EMPTY,
      input  FIFO_READ
   );

   modport slave (
      input  BUS_ADD,
      input  BUS_RD,
      input  BUS_WR,
      input  FIFO_DATA,
      input  FIFO_EMPTY,
      output FIFO_READ
   );
endinterface

// File: rtl/stream_pattern_checker.sv
// Pops words from a FWFT FIFO and checks them against a byte-counter or fixed pattern.
// Define STREAM_PATTERN_CHECKER_ERR_CAPTURE_EN to build the first-error capture registers.
module stream_pattern_checker #(
   parameter int unsigned          ABUSWIDTH = 16,
   parameter logic [ABUSWIDTH-1:0] BASEADDR  = 'h0040,
   parameter logic [ABUSWIDTH-1:0] HIGHADDR  = 'h005f
) (
   input  logic                     BUS_CLK,
   input  logic                     BUS_RST_N,
   inout  wire  [7:0]               BUS_DATA,
   stream_pattern_checker_if.slave  bus,
   output logic                     ERROR
);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      CHECK
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    conf_q, conf_d;
   logic [31:0]   fixed_q, fixed_d;
   logic [7:0]    base_q, base_d;
   logic          synced_q, synced_d;
   logic          error_q, error_d;
   logic [31:0]   wordCount_q, wordCount_d;
   logic [31:0]   errCount_q, errCount_d;
   logic [31:8]   wordSnap_q, wordSnap_d;
   logic [31:8]   errSnap_q, errSnap_d;
   logic [7:0]    readData_q;
   logic          readOe_q;

   logic [ABUSWIDTH-1:0] busOffset;
   logic                 addrHit;
   logic [4:0]           offSel;
   logic                 wrHit;
   logic                 rdHit;
   logic                 softRst;
   logic                 fifoRead;
   logic                 pop;
   logic                 mismatch;
   logic [7:0]           syncByte;
   logic [31:0]          expWord;
   logic [7:0]           readByte;
   logic [31:0]          errData;
   logic [31:0]          errExp;

   wire enable = conf_q[0];
   wire fixedMode = conf_q[1];
   wire resync = conf_q[2];

   // Offsets past the last mapped register fold onto an unused select so they read 0 and ignore writes
   assign busOffset = bus.BUS_ADD - BASEADDR;
   assign addrHit   = (bus.BUS_ADD >= BASEADDR) && (bus.BUS_ADD <= HIGHADDR);
   assign offSel    = (addrHit && (busOffset < ABUSWIDTH'(23))) ? busOffset[4:0] : 5'd31;
   assign wrHit     = bus.BUS_WR && addrHit;
   assign rdHit     = bus.BUS_RD && addrHit;
   assign softRst   = wrHit && (offSel == 5'd0);

   assign BUS_DATA      = readOe_q ? readData_q : 8'hzz;
   assign bus.FIFO_READ = fifoRead;
   assign pop           = fifoRead;
   assign ERROR         = error_q;

   // In SYNC the word is only checked against itself; afterwards against the running base or fixed word
   assign syncByte = bus.FIFO_DATA[7:0];
   always_comb begin
      expWord = fixed_q;
      if (state_q == SYNC) begin
         expWord = {syncByte + 8'd3, syncByte + 8'd2, syncByte + 8'd1, syncByte};
      end else if (!fixedMode) begin
         expWord = {base_q + 8'd3, base_q + 8'd2, base_q + 8'd1, base_q};
      end
   end
   assign mismatch = pop && (bus.FIFO_DATA != expWord);

   // FSM next state, pop strobe and all datapath next values
   always_comb begin
      state_d     = state_q;
      conf_d      = conf_q;
      fixed_d     = fixed_q;
      base_d      = base_q;
      synced_d    = synced_q;
      error_d     = error_q;
      wordCount_d = wordCount_q;
      errCount_d  = errCount_q;
      wordSnap_d  = wordSnap_q;
      errSnap_d   = errSnap_q;
      fifoRead    = 1'b0;

      case (state_q)
         SYNC, CHECK: fifoRead = !bus.FIFO_EMPTY;
         default:     fifoRead = 1'b0;
      endcase

      if (wrHit) begin
         case (offSel)
            5'd1:    conf_d         = BUS_DATA[2:0];
            5'd3:    fixed_d[7:0]   = BUS_DATA;
            5'd4:    fixed_d[15:8]  = BUS_DATA;
            5'd5:    fixed_d[23:16] = BUS_DATA;
            5'd6:    fixed_d[31:24] = BUS_DATA;
            default: ;
         endcase
      end

      if (softRst) begin
         state_d     = IDLE;
         base_d      = 8'h00;
         synced_d    = 1'b0;
         error_d     = 1'b0;
         wordCount_d = 32'h0;
         errCount_d  = 32'h0;
         wordSnap_d  = 24'h0;
         errSnap_d   = 24'h0;
      end else begin
         if (pop) begin
            if (wordCount_q != 32'hFFFF_FFFF) wordCount_d = wordCount_q + 32'd1;
            if (mismatch) begin
               error_d = 1'b1;
               if (errCount_q != 32'hFFFF_FFFF) errCount_d = errCount_q + 32'd1;
            end
            if ((state_q == SYNC) || (mismatch && resync && !fixedMode)) begin
               base_d = syncByte + 8'd4;
            end else begin
               base_d = base_q + 8'd4;
            end
         end

         case (state_q)
            IDLE:    if (enable) state_d = fixedMode ? CHECK : SYNC;
            SYNC: begin
               if (pop) begin
                  state_d  = CHECK;
                  synced_d = 1'b1;
               end
            end
            default: ;
         endcase

         if (!enable) begin
            state_d  = IDLE;
            synced_d = 1'b0;
         end

         if (rdHit && (offSel == 5'd7))  wordSnap_d = wordCount_q[31:8];
         if (rdHit && (offSel == 5'd11)) errSnap_d  = errCount_q[31:8];
      end
   end

`ifdef STREAM_PATTERN_CHECKER_ERR_CAPTURE_EN
   logic [31:0] errData_q;
   logic [31:0] errExp_q;

   // The sticky error flag doubles as "first error already captured"
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         errData_q <= 32'h0;
         errExp_q  <= 32'h0;
      end else if (softRst) begin
         errData_q <= 32'h0;
         errExp_q  <= 32'h0;
      end else if (mismatch && !error_q) begin
         errData_q <= bus.FIFO_DATA;
         errExp_q  <= expWord;
      end
   end

   assign errData = errData_q;
   assign errExp  = errExp_q;
`else
   assign errData = 32'h0;
   assign errExp  = 32'h0;
`endif

   // Upper count bytes come from the snapshot taken when the low byte was read
   always_comb begin
      readByte = 8'h00;
      case (offSel)
         5'd0:    readByte = 8'h01;
         5'd1:    readByte = {5'b0, conf_q};
         5'd2:    readByte = {6'b0, error_q, synced_q};
         5'd3:    readByte = fixed_q[7:0];
         5'd4:    readByte = fixed_q[15:8];
         5'd5:    readByte = fixed_q[23:16];
         5'd6:    readByte = fixed_q[31:24];
         5'd7:    readByte = wordCount_q[7:0];
         5'd8:    readByte = wordSnap_q[15:8];
         5'd9:    readByte = wordSnap_q[23:16];
         5'd10:   readByte = wordSnap_q[31:24];
         5'd11:   readByte = errCount_q[7:0];
         5'd12:   readByte = errSnap_q[15:8];
         5'd13:   readByte = errSnap_q[23:16];
         5'd14:   readByte = errSnap_q[31:24];
         5'd15:   readByte = errData[7:0];
         5'd16:   readByte = errData[15:8];
         5'd17:   readByte = errData[23:16];
         5'd18:   readByte = errData[31:24];
         5'd19:   readByte = errExp[7:0];
         5'd20:   readByte = errExp[15:8];
         5'd21:   readByte = errExp[23:16];
         5'd22:   readByte = errExp[31:24];
         default: readByte = 8'h00;
      endcase
   end

   // State and register file update
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         state_q     <= IDLE;
         conf_q      <= 3'b0;
         fixed_q     <= 32'h0;
         base_q      <= 8'h00;
         synced_q    <= 1'b0;
         error_q     <= 1'b0;
         wordCount_q <= 32'h0;
         errCount_q  <= 32'h0;
         wordSnap_q  <= 24'h0;
         errSnap_q   <= 24'h0;
         readData_q  <= 8'h00;
         readOe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         conf_q      <= conf_d;
         fixed_q     <= fixed_d;
         base_q      <= base_d;
         synced_q    <= synced_d;
         error_q     <= error_d;
         wordCount_q <= wordCount_d;
         errCount_q  <= errCount_d;
         wordSnap_q  <= wordSnap_d;
         errSnap_q   <= errSnap_d;
         readData_q  <= readByte;
         readOe_q    <= rdHit;
      end
   end

endmodule
